// File: rtl/sd_fifo_sync_if.sv
// srdy/drdy handshake bundle for sd_fifo_sync: producer (c_*) and consumer (p_*) sides.
// The slave modport is the FIFO's view; the master modport is the surrounding datapath's view.
interface sd_fifo_sync_if #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 32
);
  localparam int unsigned Asz = $clog2(Depth);

  logic             c_srdy;
  logic             c_drdy;
  logic [Width-1:0] c_data;
  logic [Asz:0]     c_usage;
  logic             p_srdy;
  logic             p_drdy;
  logic [Width-1:0] p_data;
  logic [Asz:0]     p_usage;

  modport slave (
    input  c_srdy, c_data, p_drdy,
    output c_drdy, c_usage, p_srdy, p_data, p_usage
  );

  modport master (
    output c_srdy, c_data, p_drdy,
    input  c_drdy, c_usage, p_srdy, p_data, p_usage
  );
endinterface

// File: rtl/sd_fifo_sync.sv
// Single-clock srdy/drdy FIFO. Flags and usage come only from registered pointers, so there
// is no combinational path from either handshake input to the opposite ready/valid.
module sd_fifo_sync #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 32
) (
  input  logic          clk_i,
  input  logic          reset_i,
  sd_fifo_sync_if.slave bus
);
  localparam int unsigned Asz = $clog2(Depth);
  localparam logic [Asz:0] PtrOne = (Asz + 1)'(1);

  logic [Width-1:0] mem_q [Depth];
  logic [Asz:0]     wp_q, wp_d;
  logic [Asz:0]     rp_q, rp_d;
  logic             empty, full;
  logic             wr_en, rd_en;

  // Extra MSB on each pointer separates full (MSBs differ) from empty (pointers equal).
  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[Asz-1:0] == rp_q[Asz-1:0]) && (wp_q[Asz] != rp_q[Asz]);

  assign wr_en = bus.c_srdy && !full;
  assign rd_en = bus.p_drdy && !empty;

  always_comb begin
    wp_d = wp_q;
    rp_d = rp_q;
    if (wr_en) wp_d = wp_q + PtrOne;
    if (rd_en) rp_d = rp_q + PtrOne;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en && !reset_i) mem_q[wp_q[Asz-1:0]] <= bus.c_data;
  end

  assign bus.c_drdy  = !full;
  assign bus.p_srdy  = !empty;
  assign bus.p_data  = mem_q[rp_q[Asz-1:0]];
  assign bus.c_usage = wp_q - rp_q;
  assign bus.p_usage = wp_q - rp_q;
endmodule

// File: tb/tb_sd_fifo_sync.sv
// Bench for sd_fifo_sync: pattern/random traffic against a queue model plus an
// incrementing-sequence checker on the consumer side.
module tb_sd_fifo_sync;
  localparam int unsigned Width = 8;
  localparam int unsigned Depth = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sd_fifo_sync_if #(.Width(Width), .Depth(Depth)) bus ();

  sd_fifo_sync #(.Width(Width), .Depth(Depth)) dut (
    .clk_i  (clk),
    .reset_i(reset),
    .bus    (bus)
  );

  int checks = 0;
  int fails = 0;
  bit mon_en = 1'b0;
  bit acc_w = 1'b0;
  logic [7:0] tx_data = 8'd0;
  logic [7:0] rx_exp = 8'd0;
  int sent = 0;
  int rep_limit = 32'h7fff_ffff;
  int ok_cnt = 0;
  int max_usage = 0;
  int cyc = 0;
  logic [Width-1:0] q[$];
  bit m_wr, m_rd;

  // Reference model: a bounded queue updated from the FIFO rules at each edge.
  always @(posedge clk) begin
    if (reset === 1'b1) begin
      q.delete();
    end else begin
      m_wr = (bus.c_srdy === 1'b1) && (q.size() < Depth);
      m_rd = (bus.p_drdy === 1'b1) && (q.size() > 0);
      if (m_rd) void'(q.pop_front());
      if (m_wr) q.push_back(bus.c_data);
    end
  end

  // Scoreboard and sequence checker, sampled mid-cycle.
  always @(negedge clk) begin
    acc_w = (bus.c_srdy === 1'b1) && (bus.c_drdy === 1'b1) && (reset === 1'b0);
    if (mon_en) begin
      checks++;
      if (bus.c_drdy !== (q.size() < Depth)) begin
        fails++;
        $display("FAIL c_drdy t=%0t got=%b want=%b", $time, bus.c_drdy, q.size() < Depth);
      end
      checks++;
      if (bus.p_srdy !== (q.size() > 0)) begin
        fails++;
        $display("FAIL p_srdy t=%0t got=%b want=%b", $time, bus.p_srdy, q.size() > 0);
      end
      checks++;
      if (int'(bus.c_usage) != q.size() || $isunknown(bus.c_usage)) begin
        fails++;
        $display("FAIL c_usage t=%0t got=%0d want=%0d", $time, bus.c_usage, q.size());
      end
      checks++;
      if (int'(bus.p_usage) != q.size() || $isunknown(bus.p_usage)) begin
        fails++;
        $display("FAIL p_usage t=%0t got=%0d want=%0d", $time, bus.p_usage, q.size());
      end
      if (q.size() > 0) begin
        checks++;
        if (bus.p_data !== q[0]) begin
          fails++;
          $display("FAIL p_data t=%0t got=%h want=%h", $time, bus.p_data, q[0]);
        end
      end
      if (int'(bus.c_usage) > max_usage) max_usage = int'(bus.c_usage);
      if (reset === 1'b1) begin
        rx_exp = tx_data;
      end else if (bus.p_srdy === 1'b1 && bus.p_drdy === 1'b1) begin
        checks++;
        if (bus.p_data !== rx_exp) begin
          fails++;
          $display("FAIL sequence t=%0t got=%h want=%h", $time, bus.p_data, rx_exp);
        end
        rx_exp++;
        ok_cnt++;
      end
    end
  end

  // One cycle of stimulus: account for the write accepted at the previous edge, then drive.
  task automatic drive(input bit rst, input bit sr, input bit dr);
    @(posedge clk);
    #2;
    if (acc_w) begin
      tx_data++;
      sent++;
    end
    reset      = rst;
    bus.c_srdy = sr && (sent < rep_limit);
    bus.c_data = tx_data;
    bus.p_drdy = dr;
    cyc++;
  endtask

  task automatic run_pat(input logic [7:0] sp, input logic [7:0] dp, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, sp[cyc % 8], dp[cyc % 8]);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 1'b1);
      mon_en = 1'b1;
    end
    drive(1'b0, 1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.c_drdy !== 1'b1) begin
      fails++;
      $display("FAIL reset_c_drdy got=%b want=1", bus.c_drdy);
    end
    checks++;
    if (bus.p_srdy !== 1'b0) begin
      fails++;
      $display("FAIL reset_p_srdy got=%b want=0", bus.p_srdy);
    end
    checks++;
    if (bus.c_usage !== '0 || bus.p_usage !== '0) begin
      fails++;
      $display("FAIL reset_usage got=%0d/%0d want=0", bus.c_usage, bus.p_usage);
    end
  endtask

  task automatic test_stream();
    int ok0 = ok_cnt;
    max_usage = 0;
    run_pat(8'hFF, 8'hFF, 50);
    checks++;
    if (max_usage > 1) begin
      fails++;
      $display("FAIL stream_usage got=%0d want<=1", max_usage);
    end
    checks++;
    if (ok_cnt - ok0 < 45) begin
      fails++;
      $display("FAIL stream_rate got=%0d want>=45", ok_cnt - ok0);
    end
  endtask

  task automatic test_pattern();
    int ok0 = ok_cnt;
    run_pat(8'h5A, 8'hFF, 8);
    run_pat(8'h5A, 8'hA5, 40);
    checks++;
    if (ok_cnt - ok0 < 10 || max_usage > Depth) begin
      fails++;
      $display("FAIL pattern got=%0d words max=%0d want>=10 max<=%0d", ok_cnt - ok0,
               max_usage, Depth);
    end
  endtask

  task automatic test_overflow();
    max_usage = 0;
    run_pat(8'hFD, 8'h03, 100);
    checks++;
    if (max_usage != Depth) begin
      fails++;
      $display("FAIL overflow_max got=%0d want=%0d", max_usage, Depth);
    end
  endtask

  task automatic test_underflow();
    run_pat(8'h11, 8'hEE, 100);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.c_usage !== '0 || bus.p_srdy !== 1'b0) begin
      fails++;
      $display("FAIL underflow got usage=%0d p_srdy=%b want 0/0", bus.c_usage, bus.p_srdy);
    end
  endtask

  task automatic test_runout();
    int ok0 = ok_cnt;
    int n = 0;
    rep_limit = sent + 1000;
    while (ok_cnt - ok0 < 1000 && n < 10000) begin
      drive(1'b0, cyc[2], !cyc[2]);
      n++;
    end
    rep_limit = 32'h7fff_ffff;
    checks++;
    if (ok_cnt - ok0 < 1000) begin
      fails++;
      $display("FAIL runout got=%0d words in %0d cycles want>=1000", ok_cnt - ok0, n);
    end
  endtask

  task automatic test_random();
    int ok0 = ok_cnt;
    for (int i = 0; i < 400; i++) drive(1'b0, 1'($urandom), 1'($urandom));
    checks++;
    if (ok_cnt - ok0 < 50) begin
      fails++;
      $display("FAIL random_progress got=%0d want>=50", ok_cnt - ok0);
    end
  endtask

  task automatic test_reset_mid();
    int ok0;
    for (int i = 0; i < 12; i++) drive(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.c_usage === '0) begin
      fails++;
      $display("FAIL prefill_usage got=%0d want>0", bus.c_usage);
    end
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.c_usage !== '0 || bus.p_srdy !== 1'b0 || bus.c_drdy !== 1'b1) begin
      fails++;
      $display("FAIL midreset got usage=%0d p_srdy=%b c_drdy=%b want 0/0/1", bus.c_usage,
               bus.p_srdy, bus.c_drdy);
    end
    ok0 = ok_cnt;
    run_pat(8'hFF, 8'hFF, 30);
    checks++;
    if (ok_cnt - ok0 < 25) begin
      fails++;
      $display("FAIL restart got=%0d want>=25", ok_cnt - ok0);
    end
  endtask

  initial begin
    reset      = 1'b1;
    bus.c_srdy = 1'b1;
    bus.p_drdy = 1'b1;
    bus.c_data = 8'd0;
    test_reset();
    test_stream();
    test_pattern();
    test_overflow();
    test_underflow();
    test_runout();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    fails++;
    $display("FAIL watchdog expired at t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $fatal(1, "watchdog");
  end
endmodule
